// File: rtl/ula4_seq_pkg.sv
// Shared definitions for the ula4 command sequencer: command kinds,
// ALU opcode constants and FSM state encoding.
package ula4_seq_pkg;

    typedef enum logic [1:0] {
        KIND_EXEC  = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_CLEAR = 2'b10,
        KIND_NOP   = 2'b11
    } cmd_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_SUM  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_EQ   = 4'd4;
    localparam logic [3:0] OP_GT   = 4'd5;
    localparam logic [3:0] OP_LT   = 4'd6;
    localparam logic [3:0] OP_NE   = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;
    localparam logic [3:0] OP_OR   = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_NOTA = 4'd14;
    localparam logic [3:0] OP_NOTB = 4'd15;

    function automatic logic is_div_zero(input logic [3:0] op, input logic [3:0] b);
        return (op == OP_DIV) && (b == 4'd0);
    endfunction

endpackage

// File: rtl/ula4_seq.sv
// Accumulator sequencer driving the external combinational ula4 ALU.
// state   | meaning
// IDLE    | ready for a command; cmd_ready=1
// EXEC    | operands presented to ALU; accumulator/flags update at exit
// RESP    | result held on res_* until res_ready handshake
module ula4_seq
    import ula4_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [3:0]       cmd_op,
    input  logic [W-1:0]     cmd_b,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_op,
    input  logic [W-1:0]     alu_out,
    input  logic             alu_ov,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             res_ov,
    output logic             res_ov_sticky,
    output logic             res_dz,
    output logic [CNT_W-1:0] op_count
);

    state_t            state, state_nxt;
    cmd_kind_t         kind_q;
    logic [W-1:0]      acc_q, b_q;
    logic [3:0]        op_q;
    logic              ov_q, sticky_q, dz_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command capture in IDLE, result commit on the single EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q   <= KIND_NOP;
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            ov_q     <= 1'b0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        kind_q <= cmd_kind_t'(cmd_kind);
                        op_q   <= cmd_op;
                        b_q    <= cmd_b;
                    end
                end
                ST_EXEC: begin
                    case (kind_q)
                        KIND_EXEC: begin
                            if (is_div_zero(op_q, b_q)) begin
                                dz_q <= 1'b1;
                                ov_q <= 1'b0;
                            end else begin
                                acc_q    <= alu_out;
                                ov_q     <= alu_ov;
                                sticky_q <= sticky_q | alu_ov;
                                dz_q     <= 1'b0;
                                cnt_q    <= cnt_q + CNT_W'(1);
                            end
                        end
                        KIND_LOAD: begin
                            acc_q <= b_q;
                            ov_q  <= 1'b0;
                            dz_q  <= 1'b0;
                        end
                        KIND_CLEAR: begin
                            acc_q    <= '0;
                            sticky_q <= 1'b0;
                            cnt_q    <= '0;
                            ov_q     <= 1'b0;
                            dz_q     <= 1'b0;
                        end
                        default: begin
                            ov_q <= 1'b0;
                            dz_q <= 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign alu_a         = acc_q;
    assign alu_b         = b_q;
    assign alu_op        = op_q;
    assign res_data      = acc_q;
    assign res_ov        = ov_q;
    assign res_ov_sticky = sticky_q;
    assign res_dz        = dz_q;
    assign op_count      = cnt_q;

endmodule

// File: tb/tb_ula4_seq.sv
// Scoreboard bench for ula4_seq with a behavioural ula4 model closing the ALU loop.
module tb_ula4_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_kind = 2'd0;
    logic [3:0] cmd_op = 4'd0;
    logic [3:0] cmd_b = 4'd0;
    logic [3:0] alu_a, alu_b, alu_op, alu_out;
    logic       alu_ov;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [3:0] res_data;
    logic       res_ov, res_ov_sticky, res_dz;
    logic [7:0] op_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] data;
        logic       ov;
        logic       sticky;
        logic       dz;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] macc = 4'd0;
    logic       msticky = 1'b0;
    logic [7:0] mcnt = 8'd0;
    bit         rand_bp = 1'b0;

    always #5 clk = ~clk;

    ula4_seq #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_ov(alu_ov),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ov(res_ov), .res_ov_sticky(res_ov_sticky),
        .res_dz(res_dz), .op_count(op_count)
    );

    // Behavioural ula4: returns {ov, out}
    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            4'd0:  begin r = ai + bi; return {r > 15, 4'(r)}; end
            4'd1:  return {1'b0, 4'(ai - bi)};
            4'd2:  begin r = ai * bi; return {r > 15, 4'(r)}; end
            4'd3:  return {1'b0, (bi == 0) ? 4'd0 : 4'(ai / bi)};
            4'd4:  return {1'b0, (ai == bi) ? 4'd1 : 4'd0};
            4'd5:  return {1'b0, (ai > bi) ? 4'd1 : 4'd0};
            4'd6:  return {1'b0, (ai < bi) ? 4'd1 : 4'd0};
            4'd7:  return {1'b0, (ai != bi) ? 4'd1 : 4'd0};
            4'd8:  return {1'b0, a & b};
            4'd9:  return {1'b0, ~(a & b)};
            4'd10: return {1'b0, a | b};
            4'd11: return {1'b0, ~(a | b)};
            4'd12: return {1'b0, a ^ b};
            4'd13: return {1'b0, ~(a ^ b)};
            4'd14: return {1'b0, ~a};
            default: return {1'b0, ~b};
        endcase
    endfunction

    always_comb {alu_ov, alu_out} = alu_ref(alu_a, alu_b, alu_op);

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: outcome of one accepted command, from the command rules alone
    task automatic model_apply(input logic [1:0] k, input logic [3:0] op, input logic [3:0] b);
        exp_t e;
        logic [4:0] r;
        e.ov = 1'b0;
        e.dz = 1'b0;
        case (k)
            2'd0: begin
                if (op == 4'd3 && b == 4'd0) begin
                    e.dz = 1'b1;
                end else begin
                    r = alu_ref(macc, b, op);
                    macc = r[3:0];
                    e.ov = r[4];
                    msticky = msticky | r[4];
                    mcnt = mcnt + 8'd1;
                end
            end
            2'd1: macc = b;
            2'd2: begin
                macc = 4'd0;
                msticky = 1'b0;
                mcnt = 8'd0;
            end
            default: ;
        endcase
        e.data = macc;
        e.sticky = msticky;
        e.cnt = mcnt;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] k, input logic [3:0] op, input logic [3:0] b);
        bit ok;
        bit rdy;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_kind = k;
        cmd_op = op;
        cmd_b = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                model_apply(k, op, b);
            end else begin
                @(negedge clk);
            end
        end
        #1;
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) done = 1'b1;
        end
        if (!done) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_alu_a"}, int'(alu_a), 0);
        chk({tag, "_alu_b"}, int'(alu_b), 0);
        chk({tag, "_alu_op"}, int'(alu_op), 0);
        chk({tag, "_res_data"}, int'(res_data), 0);
        chk({tag, "_res_ov"}, int'(res_ov), 0);
        chk({tag, "_sticky"}, int'(res_ov_sticky), 0);
        chk({tag, "_res_dz"}, int'(res_dz), 0);
        chk({tag, "_op_count"}, int'(op_count), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_bp) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare against the scoreboard on every result handshake
    initial begin
        bit prev_v, prev_r;
        exp_t e;
        prev_v = 1'b0;
        prev_r = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && !prev_r) chk("res_valid_hold", int'(res_valid), 1);
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", int'(res_data), int'(e.data));
                        chk("res_ov", int'(res_ov), int'(e.ov));
                        chk("res_ov_sticky", int'(res_ov_sticky), int'(e.sticky));
                        chk("res_dz", int'(res_dz), int'(e.dz));
                        chk("op_count", int'(op_count), int'(e.cnt));
                        chk("alu_a_eq_acc", int'(alu_a), int'(e.data));
                    end
                end
                prev_v = res_valid;
                prev_r = res_ready;
            end
        end
    end

    initial begin
        logic [1:0] k;
        logic [3:0] op, b;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // LOAD 5, EXEC sum 3 with latency checks
        send_cmd(2'd1, 4'd0, 4'd5);
        wait_drain();
        send_cmd(2'd0, 4'd0, 4'd3);
        chk("lat_exec_valid", int'(res_valid), 0);
        chk("lat_exec_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("lat_resp_valid", int'(res_valid), 1);
        chk("lat_resp_data", int'(res_data), 8);
        @(posedge clk); #1;
        chk("lat_release_valid", int'(res_valid), 0);
        chk("lat_release_ready", int'(cmd_ready), 1);
        wait_drain();

        // overflow and sticky
        send_cmd(2'd1, 4'd0, 4'd9);
        send_cmd(2'd0, 4'd0, 4'd9);
        send_cmd(2'd0, 4'd8, 4'hF);
        // divide by zero
        send_cmd(2'd1, 4'd0, 4'd6);
        send_cmd(2'd0, 4'd3, 4'd0);
        wait_drain();

        // backpressure: result held, next command stalled
        res_ready = 1'b0;
        send_cmd(2'd1, 4'd0, 4'hC);
        fork
            send_cmd(2'd0, 4'd0, 4'd1);
            begin
                @(posedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_res_valid", int'(res_valid), 1);
                    chk("bp_res_data", int'(res_data), 12);
                    chk("bp_cmd_ready", int'(cmd_ready), 0);
                end
                @(posedge clk); #2;
                res_ready = 1'b1;
            end
        join
        wait_drain();

        // randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            k = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) k = 2'd0;
            op = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            send_cmd(k, op, b);
        end
        wait_drain();
        rand_bp = 1'b0;
        @(posedge clk); #2;
        res_ready = 1'b1;

        // counter wrap, then CLEAR
        send_cmd(2'd2, 4'd0, 4'd0);
        while (mcnt != 8'd255) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd3) op = 4'd4;
            send_cmd(2'd0, op, 4'($urandom_range(0, 15)));
        end
        wait_drain();
        chk("cnt_at_255", int'(op_count), 255);
        send_cmd(2'd0, 4'd0, 4'd9);
        wait_drain();
        chk("cnt_wrapped", int'(op_count), 0);
        send_cmd(2'd1, 4'd0, 4'd9);
        send_cmd(2'd0, 4'd2, 4'd9);
        send_cmd(2'd2, 4'd0, 4'd0);
        wait_drain();
        chk("clear_acc", int'(res_data), 0);
        chk("clear_sticky", int'(res_ov_sticky), 0);

        // reset while a command is in EXEC
        send_cmd(2'd1, 4'd0, 4'd7);
        send_cmd(2'd0, 4'd0, 4'd4);
        rst = 1'b1;
        exp_q.delete();
        macc = 4'd0;
        msticky = 1'b0;
        mcnt = 8'd0;
        #1;
        check_reset_vals("rst_exec");
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_resp", int'(res_valid), 0);
        chk("rst_idle_ready", int'(cmd_ready), 1);
        send_cmd(2'd1, 4'd0, 4'd3);
        send_cmd(2'd0, 4'd1, 4'd5);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
